// File: rtl/rgd_grant_sink.sv
// rtl/rgd_grant_sink.sv - two-phase grant sink that services A/B grants and answers with done toggles
module rgd_grant_sink #(
    parameter int   SYNC_STAGES  = 2,
    parameter int   BUSY_CYCLES  = 4,
    parameter int   CNT_W        = 8,
    parameter logic PHASE_INIT_A = 1'b0,
    parameter logic PHASE_INIT_B = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grantA_req,
    input  logic             grantB_req,
    output logic             doneA,
    output logic             doneB,
    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] served_a,
    output logic [CNT_W-1:0] served_b,
    output logic             proto_err
);

    localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic                   s_a_d_q, s_b_d_q;
    logic                   done_a_q, done_a_d;
    logic                   done_b_q, done_b_d;
    logic [CNT_W-1:0]       served_a_q, served_a_d;
    logic [CNT_W-1:0]       served_b_q, served_b_d;
    logic                   err_q, err_d;
    logic                   s_a, s_b, pend_a, pend_b;

    assign s_a    = sync_a_q[SYNC_STAGES-1];
    assign s_b    = sync_b_q[SYNC_STAGES-1];
    assign pend_a = s_a ^ done_a_q;
    assign pend_b = s_b ^ done_b_q;

    // One extra flop past the synchronizer lets us spot a re-toggle during service.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_q <= {SYNC_STAGES{PHASE_INIT_A}};
            sync_b_q <= {SYNC_STAGES{PHASE_INIT_B}};
            s_a_d_q  <= PHASE_INIT_A;
            s_b_d_q  <= PHASE_INIT_B;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], grantA_req};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], grantB_req};
            s_a_d_q  <= s_a;
            s_b_d_q  <= s_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_a_q   <= PHASE_INIT_A;
            done_b_q   <= PHASE_INIT_B;
            served_a_q <= '0;
            served_b_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_a_q   <= done_a_d;
            done_b_q   <= done_b_d;
            served_a_q <= served_a_d;
            served_b_q <= served_b_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_a_d   = done_a_q;
        done_b_d   = done_b_q;
        served_a_d = served_a_q;
        served_b_d = served_b_q;
        err_d      = err_q | (pend_a & pend_b);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pend_a) begin
                    state_d = SERVE_A;
                    cnt_d   = CNT_LOAD;
                end else if (pend_b) begin
                    state_d = SERVE_B;
                    cnt_d   = CNT_LOAD;
                end
            end
            SERVE_A: begin
                if (s_a ^ s_a_d_q) err_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    done_a_d   = ~done_a_q;
                    served_a_d = served_a_q + CNT_W'(1);
                    state_d    = RELEASE;
                end
            end
            SERVE_B: begin
                if (s_b ^ s_b_d_q) err_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    done_b_d   = ~done_b_q;
                    served_b_d = served_b_q + CNT_W'(1);
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign doneA     = done_a_q;
    assign doneB     = done_b_q;
    assign busy      = (state_q == SERVE_A) || (state_q == SERVE_B);
    assign owner     = (state_q == SERVE_B);
    assign served_a  = served_a_q;
    assign served_b  = served_b_q;
    assign proto_err = err_q;

endmodule
